// File: rtl/qft_pkg.sv
// rtl/qft_pkg.sv - shared Q1.15 constants, widths and FSM state encoding
// Contents:
//   DATA_W       width of one Q1.15 word (sign + 1 integer + 15 fraction bits)
//   Q_ONE        1.0 in Q1.15, also the probability clamp ceiling
//   Q_INV_SQRT2  1/sqrt(2) in Q1.15
//   state_e      scheduler FSM states
//   prob_clamp   saturate an 18-bit unsigned sum of squares to Q_ONE
package qft_pkg;

    localparam int DATA_W = 17;

    localparam logic [DATA_W-1:0] Q_ONE       = 17'h08000;
    localparam logic [DATA_W-1:0] Q_INV_SQRT2 = 17'h05A82;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPUTE = 3'd1,
        ST_GAP     = 3'd2,
        ST_HIGH    = 3'd3,
        ST_TAIL    = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    // Rounding in the squarer can push re^2 + im^2 slightly past 1.0, and
    // a full-scale pair reaches 2.0; a probability never exceeds 1.0.
    function automatic logic [DATA_W-1:0] prob_clamp(input logic [DATA_W:0] sum);
        if (sum > {1'b0, Q_ONE}) begin
            return Q_ONE;
        end
        return sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/qft_pulse_scheduler_if.sv
// rtl/qft_pulse_scheduler_if.sv - amplitude load, run control, pulse output and debug read bundle
// Signals:
//   amp_wr, amp_idx, amp_re, amp_im   amplitude write (master -> slave)
//   start, loop                       run control (master -> slave)
//   busy, done                        run status (slave -> master)
//   sq, cur_idx                       pulse train and index being timed (slave -> master)
//   prob_rd_idx, prob_rd_data         combinational probability read-back
interface qft_pulse_scheduler_if;
    import qft_pkg::*;

    logic              amp_wr;
    logic [2:0]        amp_idx;
    logic [DATA_W-1:0] amp_re;
    logic [DATA_W-1:0] amp_im;
    logic              start;
    logic              loop;
    logic              busy;
    logic              done;
    logic              sq;
    logic [2:0]        cur_idx;
    logic [2:0]        prob_rd_idx;
    logic [DATA_W-1:0] prob_rd_data;

    modport master (
        output amp_wr, amp_idx, amp_re, amp_im, start, loop, prob_rd_idx,
        input  busy, done, sq, cur_idx, prob_rd_data
    );

    modport slave (
        input  amp_wr, amp_idx, amp_re, amp_im, start, loop, prob_rd_idx,
        output busy, done, sq, cur_idx, prob_rd_data
    );

endinterface

// File: rtl/q15_mul.sv
// rtl/q15_mul.sv - combinational signed Q1.15 multiplier
// Ports:
//   a, b  in   signed Q1.15 operands
//   p     out  (a*b) as a 34-bit signed product, >>> 15, low 17 bits
module q15_mul
    import qft_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] p
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    assign p    = DATA_W'(prod >>> 15);

endmodule

// File: rtl/qft_pulse_scheduler.sv
// rtl/qft_pulse_scheduler.sv - squares 8 complex amplitudes on one multiplier and emits one timed pulse per basis state
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of qft_pulse_scheduler_if:
//         amp_wr/amp_idx/amp_re/amp_im  amplitude write, IDLE only
//         start/loop                     run control
//         busy/done                      run status
//         sq/cur_idx                     registered pulse train, index being timed
//         prob_rd_idx/prob_rd_data       combinational probability read
module qft_pulse_scheduler
    import qft_pkg::*;
#(
    parameter int PULSE_UNIT = 64,
    parameter int GAP        = 4,
    parameter int TAIL       = 8,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rst,
    qft_pulse_scheduler_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_COMPUTE = 3'(ST_COMPUTE);
    localparam logic [2:0] S_GAP     = 3'(ST_GAP);
    localparam logic [2:0] S_HIGH    = 3'(ST_HIGH);
    localparam logic [2:0] S_TAIL    = 3'(ST_TAIL);
    localparam logic [2:0] S_FIN     = 3'(ST_FIN);

    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TAIL_LOAD = CNT_W'(TAIL - 1);

    logic [2:0]               state;
    logic [3:0]               step;
    logic [2:0]               k;
    logic [CNT_W-1:0]         cnt;
    logic                     sq_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     loop_q;
    logic signed [DATA_W-1:0] sq_re;

    logic signed [DATA_W-1:0] amp_re_q [8];
    logic signed [DATA_W-1:0] amp_im_q [8];
    logic        [DATA_W-1:0] prob_q   [8];

    // Even steps square the real part, odd steps the imaginary part of
    // amplitude step>>1, so the single multiplier covers all 16 squarings.
    logic signed [DATA_W-1:0] mul_op;
    logic signed [DATA_W-1:0] mul_p;
    logic        [DATA_W:0]   sum_sq;

    assign mul_op = step[0] ? amp_im_q[step[3:1]] : amp_re_q[step[3:1]];

    q15_mul u_mul (
        .a (mul_op),
        .b (mul_op),
        .p (mul_p)
    );

    assign sum_sq = {1'b0, sq_re} + {1'b0, mul_p};

    // Pulse width for the index being timed: prob scaled so that 1.0 maps
    // to PULSE_UNIT cycles, fraction truncated.
    logic [CNT_W+DATA_W-1:0] w_prod;
    logic [CNT_W-1:0]        w_k;

    assign w_prod = (CNT_W+DATA_W)'(prob_q[k]) * (CNT_W+DATA_W)'(PULSE_UNIT);
    assign w_k    = CNT_W'(w_prod >> 15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            step   <= '0;
            k      <= '0;
            cnt    <= '0;
            sq_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            loop_q <= 1'b0;
            sq_re  <= '0;
            for (int i = 0; i < 8; i++) begin
                amp_re_q[i] <= '0;
                amp_im_q[i] <= '0;
                prob_q[i]   <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.amp_wr) begin
                        amp_re_q[bus.amp_idx] <= bus.amp_re;
                        amp_im_q[bus.amp_idx] <= bus.amp_im;
                    end
                    if (bus.start) begin
                        state  <= S_COMPUTE;
                        step   <= '0;
                        busy_q <= 1'b1;
                    end
                end

                S_COMPUTE: begin
                    if (!step[0]) begin
                        sq_re <= mul_p;
                    end else begin
                        prob_q[step[3:1]] <= prob_clamp(sum_sq);
                    end
                    if (step == 4'd15) begin
                        state <= S_GAP;
                        step  <= '0;
                        k     <= '0;
                        cnt   <= GAP_LOAD;
                    end else begin
                        step <= step + 4'd1;
                    end
                end

                S_GAP: begin
                    if (cnt == '0) begin
                        if (w_k != '0) begin
                            state <= S_HIGH;
                            cnt   <= w_k - CNT_W'(1);
                            sq_q  <= 1'b1;
                        end else if (k == 3'd7) begin
                            state <= S_TAIL;
                            cnt   <= TAIL_LOAD;
                        end else begin
                            k   <= k + 3'd1;
                            cnt <= GAP_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_HIGH: begin
                    if (cnt == '0) begin
                        sq_q <= 1'b0;
                        if (k == 3'd7) begin
                            state <= S_TAIL;
                            cnt   <= TAIL_LOAD;
                        end else begin
                            state <= S_GAP;
                            k     <= k + 3'd1;
                            cnt   <= GAP_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_TAIL: begin
                    if (cnt == '0) begin
                        state  <= S_FIN;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        loop_q <= bus.loop;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_FIN: begin
                    if (loop_q) begin
                        state  <= S_COMPUTE;
                        step   <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sq           = sq_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cur_idx      = (state == S_COMPUTE) ? step[3:1] : k;
    assign bus.prob_rd_data = prob_q[bus.prob_rd_idx];

endmodule
